free_list: RTL and testbench

- Physical-register free list for the 2-wide R10000 rename path.
- Sits upstream of the ROB, beside the map table.
- Supplies up to two free physical tags (T_idx) per dispatch cycle to the ROB and map table.
- Reclaims Told tags from ROB retirement.
- Restores its allocation pointer on branch rollback using a per-ROB-entry head checkpoint.

---
 rtl/sys_defs.sv | 27 ++
 rtl/free_list.sv | 98 +++++++++
 tb/tb_free_list.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/sys_defs.sv
// Shared sizing constants and the rename-path interface structs used between
// the free list and the ROB.
package sys_defs;

    localparam int NUM_SUPER = 2;
    localparam int NUM_PR    = 64;
    localparam int NUM_ARCH  = 32;
    localparam int NUM_FL    = NUM_PR - NUM_ARCH;
    localparam int NUM_ROB   = 32;

    localparam int PR_W  = $clog2(NUM_PR);
    localparam int ROB_W = $clog2(NUM_ROB);
    localparam int FL_W  = $clog2(NUM_FL);
    // Free-list pointers carry one extra wrap bit above the array index.
    localparam int PTR_W = FL_W + 1;

    // Tags handed to the ROB / map table for the two dispatching lanes.
    typedef struct packed {
        logic [NUM_SUPER-1:0][PR_W-1:0] T_idx;
    } FL_ROB_OUT_t;

    // Previous mappings released by the two retiring lanes.
    typedef struct packed {
        logic [NUM_SUPER-1:0][PR_W-1:0] Told_idx;
    } ROB_FL_OUT_t;

endpackage

// File: rtl/free_list.sv
// Physical-register free list for a 2-wide rename path. Pops two tags per
// dispatch, pushes retired Told tags at the tail, and restores the head from a
// per-ROB-entry checkpoint on branch rollback.
module free_list
    import sys_defs::*;
(
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             en,
    input  logic                             dispatch_en,
    input  logic [NUM_SUPER-1:0][ROB_W-1:0]  ROB_idx,
    input  logic [NUM_SUPER-1:0]             retire_en,
    input  ROB_FL_OUT_t                      ROB_FL_out,
    input  logic                             rollback_en,
    input  logic [ROB_W-1:0]                 ROB_rollback_idx,
    output FL_ROB_OUT_t                      FL_ROB_out,
    output logic                             FL_valid
);

    logic [PR_W-1:0]  list_reg [NUM_FL];
    logic [PTR_W-1:0] ckpt_reg [NUM_ROB];
    logic [PTR_W-1:0] head_reg;
    logic [PTR_W-1:0] tail_reg;

    logic [PTR_W-1:0] head_p1;
    logic [PTR_W-1:0] head_p2;
    logic [PTR_W-1:0] tail_p1;
    logic [PTR_W-1:0] count;
    logic [1:0]       push_cnt;
    logic             do_dispatch;

    assign head_p1     = head_reg + PTR_W'(1);
    assign head_p2     = head_reg + PTR_W'(2);
    assign tail_p1     = tail_reg + PTR_W'(1);
    // Wrap bit makes tail - head unambiguous between empty (0) and full (NUM_FL).
    assign count       = tail_reg - head_reg;
    assign push_cnt    = {1'b0, retire_en[0]} + {1'b0, retire_en[1]};
    // Rollback overrides any dispatch presented in the same cycle.
    assign do_dispatch = en && dispatch_en && !rollback_en;

    // Zero-latency peek at the next two free tags.
    assign FL_ROB_out.T_idx[0] = list_reg[head_reg[FL_W-1:0]];
    assign FL_ROB_out.T_idx[1] = list_reg[head_p1[FL_W-1:0]];
    assign FL_valid            = (count >= PTR_W'(NUM_SUPER));

    // Tag storage: reset to the non-architectural tags, retire writes at tail.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_FL; i++) begin
                list_reg[i] <= PR_W'(NUM_ARCH + i);
            end
        end else if (en) begin
            if (retire_en[0]) list_reg[tail_reg[FL_W-1:0]] <= ROB_FL_out.Told_idx[0];
            if (retire_en[1]) list_reg[tail_p1[FL_W-1:0]]  <= ROB_FL_out.Told_idx[1];
        end
    end

    // Head/tail pointers: dispatch pops two, rollback restores, retire pushes.
    always_ff @(posedge clock) begin
        if (reset) begin
            head_reg <= '0;
            tail_reg <= PTR_W'(NUM_FL);
        end else if (en) begin
            if (rollback_en) begin
                head_reg <= ckpt_reg[ROB_rollback_idx];
            end else if (dispatch_en) begin
                head_reg <= head_p2;
            end
            tail_reg <= tail_reg + PTR_W'(push_cnt);
        end
    end

    // Each ROB slot remembers the head just past its own allocation, so a
    // rollback to it keeps the branch's tag and frees everything younger.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_ROB; i++) begin
                ckpt_reg[i] <= '0;
            end
        end else if (do_dispatch) begin
            ckpt_reg[ROB_idx[0]] <= head_p1;
            ckpt_reg[ROB_idx[1]] <= head_p2;
        end
    end

    // Simulation-only guards on protocol violations from the ROB / dispatch.
    always_ff @(posedge clock) begin
        if (!reset && en) begin
            assert (!do_dispatch || count >= PTR_W'(NUM_SUPER))
                else $error("free_list: dispatch with fewer than two free tags");
            assert (retire_en != 2'b10)
                else $error("free_list: retire lane1 without lane0");
            assert ((PTR_W+1)'(count) + (PTR_W+1)'(push_cnt) <= (PTR_W+1)'(NUM_FL))
                else $error("free_list: push into a full list");
        end
    end

endmodule

// File: tb/tb_free_list.sv
// Directed bench for free_list: reset image, drain to empty, refill, rollback,
// concurrent dispatch/retire across the pointer wrap, stall and mid-run reset.
module tb_free_list;
    import sys_defs::*;

    logic                            clock = 1'b0;
    logic                            reset;
    logic                            en;
    logic                            dispatch_en;
    logic [NUM_SUPER-1:0][ROB_W-1:0] ROB_idx;
    logic [NUM_SUPER-1:0]            retire_en;
    ROB_FL_OUT_t                     ROB_FL_out;
    logic                            rollback_en;
    logic [ROB_W-1:0]                ROB_rollback_idx;
    FL_ROB_OUT_t                     FL_ROB_out;
    logic                            FL_valid;

    int checks = 0;
    int errors = 0;
    int txn    = 0;

    free_list dut (
        .clock            (clock),
        .reset            (reset),
        .en               (en),
        .dispatch_en      (dispatch_en),
        .ROB_idx          (ROB_idx),
        .retire_en        (retire_en),
        .ROB_FL_out       (ROB_FL_out),
        .rollback_en      (rollback_en),
        .ROB_rollback_idx (ROB_rollback_idx),
        .FL_ROB_out       (FL_ROB_out),
        .FL_valid         (FL_valid)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input int t1, input int t0, input int valid);
        check({tag, ".T0"}, 32'(FL_ROB_out.T_idx[0]), t0);
        check({tag, ".T1"}, 32'(FL_ROB_out.T_idx[1]), t1);
        check({tag, ".valid"}, 32'(FL_valid), valid);
    endtask

    task automatic idle();
        en               = 1'b1;
        dispatch_en      = 1'b0;
        ROB_idx          = '0;
        retire_en        = 2'b00;
        ROB_FL_out       = '0;
        rollback_en      = 1'b0;
        ROB_rollback_idx = '0;
    endtask

    // One clock; outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clock);
        #1;
        txn++;
        $display("txn %0d rst=%b en=%b disp=%b ret=%b rb=%b -> T=%0d,%0d valid=%b",
                 txn, reset, en, dispatch_en, retire_en, rollback_en,
                 FL_ROB_out.T_idx[1], FL_ROB_out.T_idx[0], FL_valid);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    int lane0_prev;
    int lane1_prev;
    int lane0;
    int lane1;

    initial begin
        idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        // Reset image after one idle cycle.
        tick();
        check_out("reset", 33, 32, 1);
        check("reset.count", 32'(dut.count), 32);

        // Drain: 16 back-to-back pair dispatches.
        for (int k = 0; k < 16; k++) begin
            check_out($sformatf("drain%0d", k), 33 + 2*k, 32 + 2*k, 1);
            dispatch_en = 1'b1;
            ROB_idx[0]  = ROB_W'(2*k);
            ROB_idx[1]  = ROB_W'(2*k + 1);
            tick();
        end
        idle();
        check("empty.valid", 32'(FL_valid), 0);
        check("empty.count", 32'(dut.count), 0);

        // Refill two tags from an empty list.
        retire_en              = 2'b11;
        ROB_FL_out.Told_idx[0] = 6'd4;
        ROB_FL_out.Told_idx[1] = 6'd5;
        tick();
        idle();
        check_out("refill", 5, 4, 1);
        check("refill.count", 32'(dut.count), 2);

        // Three pair dispatches then rollback to ROB slot 2 (dispatch ignored).
        do_reset();
        for (int k = 0; k < 3; k++) begin
            dispatch_en = 1'b1;
            ROB_idx[0]  = ROB_W'(2*k);
            ROB_idx[1]  = ROB_W'(2*k + 1);
            tick();
        end
        check_out("pre_rb", 39, 38, 1);
        rollback_en      = 1'b1;
        ROB_rollback_idx = 5'd2;
        ROB_idx[0]       = 5'd6;
        ROB_idx[1]       = 5'd7;
        tick();
        idle();
        check_out("rollback", 36, 35, 1);
        check("rollback.count", 32'(dut.count), 29);

        // Bring count to 2 with head at index 30, then dispatch + dual retire
        // every cycle until the tail crosses index 31 -> 0 and wraps.
        do_reset();
        for (int k = 0; k < 15; k++) begin
            dispatch_en = 1'b1;
            ROB_idx[0]  = ROB_W'(2*k);
            ROB_idx[1]  = ROB_W'(2*k + 1);
            tick();
        end
        idle();
        check("steady.count", 32'(dut.count), 2);
        lane0_prev = 62;
        lane1_prev = 63;
        for (int j = 0; j < 16; j++) begin
            check_out($sformatf("steady%0d", j), lane1_prev, lane0_prev, 1);
            lane0 = (j == 15) ? 11 : (2*j + 40) % 64;
            lane1 = (j == 15) ? 10 : (2*j + 41) % 64;
            dispatch_en            = 1'b1;
            ROB_idx[0]             = ROB_W'(2*j);
            ROB_idx[1]             = ROB_W'(2*j + 1);
            retire_en              = 2'b11;
            ROB_FL_out.Told_idx[0] = 6'(lane0);
            ROB_FL_out.Told_idx[1] = 6'(lane1);
            tick();
            lane0_prev = lane0;
            lane1_prev = lane1;
        end
        idle();
        check_out("wrap", 10, 11, 1);
        check("wrap.count", 32'(dut.count), 2);
        check("wrap.tail", 32'(dut.tail_reg), 0);

        // Retire into the wrapped indices 0/1, then pop them.
        retire_en              = 2'b11;
        ROB_FL_out.Told_idx[0] = 6'd20;
        ROB_FL_out.Told_idx[1] = 6'd21;
        tick();
        idle();
        check("wrap_ret.count", 32'(dut.count), 4);
        dispatch_en = 1'b1;
        tick();
        idle();
        check_out("wrap_pop", 21, 20, 1);
        check("wrap_pop.count", 32'(dut.count), 2);

        // Stall: every request asserted with en low changes nothing.
        en                     = 1'b0;
        dispatch_en            = 1'b1;
        retire_en              = 2'b11;
        ROB_FL_out.Told_idx[0] = 6'd1;
        ROB_FL_out.Told_idx[1] = 6'd2;
        rollback_en            = 1'b1;
        ROB_rollback_idx       = 5'd5;
        tick();
        tick();
        check_out("stall", 21, 20, 1);
        check("stall.count", 32'(dut.count), 2);

        // Reset with requests pending restores the initial list.
        en    = 1'b1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        idle();
        check_out("midreset", 33, 32, 1);
        check("midreset.count", 32'(dut.count), 32);
        dispatch_en = 1'b1;
        tick();
        idle();
        check_out("post_reset", 35, 34, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
